pio_access_arbiter: RTL and testbench

- Shares one Avalon-MM PIO output-register slave between two requesters: requester 0 is the HPS lightweight-bridge shim, requester 1 is the FPGA-side timing/measurement engine.
- Requesters are served round-robin. Each transaction is a single-beat read or write to the PIO.
- The block drives the PIO's address, chipselect, write_n and writedata, and captures its combinational readdata.
- Optional per-requester wait-time statistics support ARM-vs-FPGA latency measurements.

---
 rtl/pio_access_arbiter.sv | 253 +++++++++++++++++++++++++
 tb/tb_pio_access_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_access_arbiter.sv
// ---------------------------------------------------------------------------
// pio_access_arbiter
//
// Shares one Avalon-MM PIO output-register slave between two requesters
// (0 = HPS lightweight-bridge shim, 1 = FPGA timing/measurement engine).
// Requesters are served round-robin, one single-beat read or write at a time.
// Every transaction takes IDLE -> ISSUE -> RESP. The PIO bus is driven only
// during ISSUE. The owner's ack pulses during RESP.
//
// Optional feature macro: PIO_ARB_WAIT_STATS_EN
//   When defined, the block keeps a per-requester wait counter and a max-wait
//   statistic, and adds the stats_clr / max_wait0 / max_wait1 ports.
//
// Ports
//   clk                  single clock (block and PIO)
//   reset_n              synchronous, active-low reset
//   req0/req1            request; the requester holds it and its fields until ack
//   we0/we1              1 = write, 0 = read
//   addr0/addr1          PIO register address
//   wdata0/wdata1        write data
//   ack0/ack1            one-cycle completion pulse
//   rdata0/rdata1        read result; held until that requester's next read
//   address, chipselect,
//   write_n, writedata   registered PIO bus outputs (idle except in ISSUE)
//   readdata             PIO read data, combinational on address
//   stats_clr            (stats build) clears both max-wait values
//   max_wait0/max_wait1  (stats build) longest observed wait, in cycles
// ---------------------------------------------------------------------------
module pio_access_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 2,
    parameter int WAIT_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] address,
    output logic              chipselect,
    output logic              write_n,
    output logic [DATA_W-1:0] writedata,
    input  logic [DATA_W-1:0] readdata
`ifdef PIO_ARB_WAIT_STATS_EN
    ,
    input  logic              stats_clr,
    output logic [WAIT_W-1:0] max_wait0,
    output logic [WAIT_W-1:0] max_wait1
`endif
);

    // Elaboration-time sanity check on the widths.
    if (DATA_W < 1 || ADDR_W < 1 || WAIT_W < 1) begin : g_param_check
        $error("pio_access_arbiter: DATA_W, ADDR_W and WAIT_W must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Requester inputs gathered into indexable form.
    logic [1:0]        w_req;
    logic [1:0]        w_we;
    logic [ADDR_W-1:0] w_addr  [2];
    logic [DATA_W-1:0] w_wdata [2];

    assign w_req      = {req1, req0};
    assign w_we       = {we1, we0};
    assign w_addr[0]  = addr0;
    assign w_addr[1]  = addr1;
    assign w_wdata[0] = wdata0;
    assign w_wdata[1] = wdata1;

    // Latched transaction and arbitration history.
    logic r_owner;
    logic r_we;
    logic r_last_grant;

    // Registered PIO bus and ack pulses.
    logic              r_chipselect;
    logic              r_write_n;
    logic [ADDR_W-1:0] r_address;
    logic [DATA_W-1:0] r_writedata;
    logic [1:0]        r_ack;

    // Next values for the registered outputs.
    logic              w_chipselect_next;
    logic              w_write_n_next;
    logic [ADDR_W-1:0] w_address_next;
    logic [DATA_W-1:0] w_writedata_next;
    logic [1:0]        w_ack_next;

    // Selection: a lone request wins outright. On a tie the requester that
    // did not get the previous grant wins.
    logic w_sel_valid;
    logic w_sel;

    always_comb begin
        w_sel_valid = (r_state == IDLE) && (|w_req);
        w_sel       = (&w_req) ? ~r_last_grant : w_req[1];
    end

    // Next-state and next-output logic. The PIO bus next values are computed
    // here so the bus itself comes straight from flops.
    always_comb begin
        w_state_next      = r_state;
        w_chipselect_next = 1'b0;
        w_write_n_next    = 1'b1;
        w_address_next    = '0;
        w_writedata_next  = '0;
        w_ack_next        = '0;
        case (r_state)
            IDLE: begin
                if (w_sel_valid) begin
                    w_state_next      = ISSUE;
                    w_chipselect_next = 1'b1;
                    w_write_n_next    = ~w_we[w_sel];
                    w_address_next    = w_addr[w_sel];
                    w_writedata_next  = w_we[w_sel] ? w_wdata[w_sel] : '0;
                end
            end
            ISSUE: begin
                w_state_next      = RESP;
                w_ack_next[r_owner] = 1'b1;
            end
            RESP: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_owner      <= 1'b0;
            r_we         <= 1'b0;
            r_last_grant <= 1'b1;
            r_chipselect <= 1'b0;
            r_write_n    <= 1'b1;
            r_address    <= '0;
            r_writedata  <= '0;
            r_ack        <= '0;
        end else begin
            r_state      <= w_state_next;
            r_chipselect <= w_chipselect_next;
            r_write_n    <= w_write_n_next;
            r_address    <= w_address_next;
            r_writedata  <= w_writedata_next;
            r_ack        <= w_ack_next;
            if (w_sel_valid) begin
                r_owner      <= w_sel;
                r_we         <= w_we[w_sel];
                r_last_grant <= w_sel;
            end
        end
    end

    assign chipselect = r_chipselect;
    assign write_n    = r_write_n;
    assign address    = r_address;
    assign writedata  = r_writedata;
    assign ack0       = r_ack[0];
    assign ack1       = r_ack[1];

    // Per-requester state: read-data holding register and, optionally,
    // the wait statistics.
    logic [DATA_W-1:0] w_rdata [2];

`ifdef PIO_ARB_WAIT_STATS_EN
    logic [1:0]        w_pick;
    logic [WAIT_W-1:0] w_max_wait [2];

    always_comb begin
        w_pick = '0;
        if (w_sel_valid) begin
            w_pick[w_sel] = 1'b1;
        end
    end
`endif

    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        localparam logic ID = 1'(gi);

        logic [DATA_W-1:0] r_rdata;

        // readdata is valid during ISSUE because address is already driven.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                r_rdata <= '0;
            end else if (r_state == ISSUE && !r_we && r_owner == ID) begin
                r_rdata <= readdata;
            end
        end

        assign w_rdata[gi] = r_rdata;

`ifdef PIO_ARB_WAIT_STATS_EN
        logic [WAIT_W-1:0] r_wait_cnt;
        logic [WAIT_W-1:0] r_max_wait;

        // The count folded into max_wait on selection is the value before
        // this cycle; the selection cycle itself is not counted as waiting.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                r_wait_cnt <= '0;
                r_max_wait <= '0;
            end else if (w_pick[gi]) begin
                r_wait_cnt <= '0;
                if (stats_clr) begin
                    r_max_wait <= '0;
                end else if (r_wait_cnt > r_max_wait) begin
                    r_max_wait <= r_wait_cnt;
                end
            end else begin
                if (w_req[gi] && r_owner != ID && r_wait_cnt != {WAIT_W{1'b1}}) begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                end
                if (stats_clr) begin
                    r_max_wait <= '0;
                end
            end
        end

        assign w_max_wait[gi] = r_max_wait;
`endif
    end

    assign rdata0 = w_rdata[0];
    assign rdata1 = w_rdata[1];

`ifdef PIO_ARB_WAIT_STATS_EN
    assign max_wait0 = w_max_wait[0];
    assign max_wait1 = w_max_wait[1];
`endif

endmodule

// File: tb/tb_pio_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pio_access_arbiter
//
// Bench for pio_access_arbiter, with a small PIO output-register model as the
// slave (reset value 1023, register at address 0 only). It runs directed
// scenarios first, then randomized requester traffic. A timestamp-based
// reference model predicts grants, bus activity, acks, read data, the PIO
// register and (stats build, PIO_ARB_WAIT_STATS_EN) the max-wait values.
// ---------------------------------------------------------------------------
module tb_pio_access_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 2;
    localparam int WAIT_W = 16;
    localparam int WAIT_MAX = (1 << WAIT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n;
    logic              a_req   [2];
    logic              a_we    [2];
    logic [ADDR_W-1:0] a_addr  [2];
    logic [DATA_W-1:0] a_wdata [2];
    int                a_wait  [2];

    logic              ack0, ack1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic [ADDR_W-1:0] address;
    logic              chipselect, write_n;
    logic [DATA_W-1:0] writedata, readdata;
`ifdef PIO_ARB_WAIT_STATS_EN
    logic              stats_clr;
    logic [WAIT_W-1:0] max_wait0, max_wait1;
`endif

    pio_access_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .WAIT_W(WAIT_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req0       (a_req[0]),
        .req1       (a_req[1]),
        .we0        (a_we[0]),
        .we1        (a_we[1]),
        .addr0      (a_addr[0]),
        .addr1      (a_addr[1]),
        .wdata0     (a_wdata[0]),
        .wdata1     (a_wdata[1]),
        .ack0       (ack0),
        .ack1       (ack1),
        .rdata0     (rdata0),
        .rdata1     (rdata1),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata)
`ifdef PIO_ARB_WAIT_STATS_EN
        ,
        .stats_clr  (stats_clr),
        .max_wait0  (max_wait0),
        .max_wait1  (max_wait1)
`endif
    );

    // PIO output-register slave.
    logic [DATA_W-1:0] pio_out;
    always @(posedge clk) begin
        if (!reset_n) pio_out <= 32'd1023;
        else if (chipselect && !write_n && address == '0) pio_out <= writedata;
    end
    assign readdata = (address == '0) ? pio_out : '0;

    // Checking.
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model, expressed in edge timestamps. A grant at edge g puts
    // the bus active after g, acks after g+1, and the next grant can happen
    // at edge g+3 at the earliest.
    int                edge_no = 0;
    int                m_g     = -10;
    int                m_last  = 1;
    int                m_owner = 0;
    logic              m_we    = 1'b0;
    logic [ADDR_W-1:0] m_addr  = '0;
    logic [DATA_W-1:0] m_wd    = '0;
    logic [DATA_W-1:0] m_pio   = 32'd1023;
    logic [DATA_W-1:0] m_rd    [2];
    int                m_cnt   [2];
    int                m_max   [2];

    logic              e_cs, e_wn;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wd;
    logic              e_ack   [2];

    int mode = 0;        // 0: drop on ack, 1: reissue on ack, 2: random
    int grant_log [$];

    task automatic model_edge();
        int e;
        int win;
        e   = edge_no;
        win = -1;
        if (!reset_n) begin
            m_g = -10; m_last = 1; m_owner = 0; m_we = 1'b0; m_addr = '0; m_wd = '0;
            m_pio = 32'd1023;
            for (int i = 0; i < 2; i++) begin m_rd[i] = '0; m_cnt[i] = 0; m_max[i] = 0; end
        end else begin
            if (e == m_g + 1) begin
                if (!m_we) m_rd[m_owner] = (m_addr == '0) ? m_pio : '0;
                else if (m_addr == '0) m_pio = m_wd;
            end
            if (e >= m_g + 3 && (a_req[0] || a_req[1]))
                win = (a_req[0] && a_req[1]) ? (1 - m_last) : (a_req[1] ? 1 : 0);
`ifdef PIO_ARB_WAIT_STATS_EN
            for (int i = 0; i < 2; i++) begin
                if (win == i) begin
                    m_max[i] = stats_clr ? 0 : ((m_cnt[i] > m_max[i]) ? m_cnt[i] : m_max[i]);
                    m_cnt[i] = 0;
                end else begin
                    if (a_req[i] && m_owner != i && m_cnt[i] < WAIT_MAX) m_cnt[i]++;
                    if (stats_clr) m_max[i] = 0;
                end
            end
`endif
            if (win >= 0) begin
                m_g = e; m_last = win; m_owner = win;
                m_we = a_we[win]; m_addr = a_addr[win]; m_wd = a_wdata[win];
            end
        end
        e_cs   = (e == m_g);
        e_wn   = !(e_cs && m_we);
        e_addr = e_cs ? m_addr : '0;
        e_wd   = (e_cs && m_we) ? m_wd : '0;
        for (int i = 0; i < 2; i++) e_ack[i] = (e == m_g + 1) && (m_owner == i);
        edge_no++;
    endtask

    task automatic new_txn(input int i);
        a_req[i]   = 1'b1;
        a_we[i]    = 1'($urandom_range(0, 1));
        a_addr[i]  = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom_range(0, 3)) : '0;
        a_wdata[i] = $urandom;
    endtask

    task automatic set_txn(input int i, input logic we, input logic [ADDR_W-1:0] ad,
                           input logic [DATA_W-1:0] wd);
        a_req[i] = 1'b1; a_we[i] = we; a_addr[i] = ad; a_wdata[i] = wd;
    endtask

    task automatic agents();
        logic ak;
        for (int i = 0; i < 2; i++) begin
            ak = (i == 0) ? ack0 : ack1;
            if (a_req[i] && ak) begin
                $display("txn req%0d %s addr=%0d wdata=0x%08h rdata=0x%08h",
                         i, a_we[i] ? "WR" : "RD", a_addr[i], a_wdata[i],
                         (i == 0) ? rdata0 : rdata1);
                grant_log.push_back(i);
                a_wait[i] = 0;
                if (mode == 1 || (mode == 2 && $urandom_range(0, 3) == 0)) new_txn(i);
                else a_req[i] = 1'b0;
            end else if (a_req[i]) begin
                a_wait[i]++;
            end else if (mode == 2 && $urandom_range(0, 2) == 0) begin
                new_txn(i);
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check("chipselect", chipselect, e_cs);
        check("write_n", write_n, e_wn);
        check("address", address, e_addr);
        check("writedata", writedata, e_wd);
        check("ack0", ack0, e_ack[0]);
        check("ack1", ack1, e_ack[1]);
        check("rdata0", rdata0, m_rd[0]);
        check("rdata1", rdata1, m_rd[1]);
        check("pio_out", pio_out, m_pio);
`ifdef PIO_ARB_WAIT_STATS_EN
        check("max_wait0", max_wait0, m_max[0]);
        check("max_wait1", max_wait1, m_max[1]);
`endif
        check("ack_timeout0", a_wait[0] > 20, 0);
        check("ack_timeout1", a_wait[1] > 20, 0);
        agents();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        a_req[0] = 1'b0; a_req[1] = 1'b0;
        a_wait[0] = 0; a_wait[1] = 0;
        step(); step();
        reset_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            a_req[i] = 1'b0; a_we[i] = 1'b0; a_addr[i] = '0; a_wdata[i] = '0; a_wait[i] = 0;
            m_rd[i] = '0; m_cnt[i] = 0; m_max[i] = 0;
        end
`ifdef PIO_ARB_WAIT_STATS_EN
        stats_clr = 1'b0;
`endif
        mode = 0;
        do_reset();
        check("rst_cs", chipselect, 0);
        check("rst_wn", write_n, 1);
        check("rst_rdata0", rdata0, 0);

        // Single write from requester 0.
        set_txn(0, 1'b1, 2'd0, 32'h0000_00AA);
        step();
        check("wr_cs_c1", chipselect, 1);
        check("wr_wn_c1", write_n, 0);
        step();
        check("wr_ack0_c2", ack0, 1);
        check("wr_cs_c2", chipselect, 0);
        check("wr_pio_c2", pio_out, 32'hAA);
        step();

        // Read of the PIO reset value by requester 1.
        do_reset();
        set_txn(1, 1'b0, 2'd0, '0);
        step(); step();
        check("rd_ack1", ack1, 1);
        check("rd_rdata1", rdata1, 32'h3FF);
        step();

        // Simultaneous requests after reset.
        do_reset();
        set_txn(0, 1'b0, 2'd0, '0);
        set_txn(1, 1'b0, 2'd0, '0);
        step(); check("tie_cs_c1", chipselect, 1);
        step(); check("tie_ack0_c2", ack0, 1);
        step();
        step(); check("tie_cs_c4", chipselect, 1);
        step(); check("tie_ack1_c5", ack1, 1); check("tie_ack0_c5", ack0, 0);
`ifdef PIO_ARB_WAIT_STATS_EN
        check("tie_max_wait0", max_wait0, 0);
        check("tie_max_wait1", max_wait1, 3);
        stats_clr = 1'b1;
        step();
        stats_clr = 1'b0;
        check("clr_max_wait1", max_wait1, 0);
`endif
        step();

        // Continuous requests from both: grants alternate.
        grant_log.delete();
        mode = 1;
        set_txn(0, 1'b1, 2'd0, 32'h11);
        set_txn(1, 1'b1, 2'd0, 32'h22);
        for (int k = 0; k < 24; k++) step();
        mode = 0;
        for (int k = 0; k < 8; k++) step();
        check("alt_count", grant_log.size() >= 6, 1);
        for (int k = 0; k < grant_log.size(); k++) check("alt_grant", grant_log[k], k % 2);

        // Reset during the ISSUE cycle of a requester-1 write.
        do_reset();
        set_txn(1, 1'b1, 2'd0, 32'h55);
        step();
        check("rsti_cs_issue", chipselect, 1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        a_req[1] = 1'b0;
        check("rsti_cs", chipselect, 0);
        check("rsti_ack1", ack1, 0);
        step();
        check("rsti_ack1_later", ack1, 0);
        check("rsti_pio", pio_out, 32'd1023);
        set_txn(0, 1'b0, 2'd0, '0);
        set_txn(1, 1'b0, 2'd0, '0);
        step(); step();
        check("rsti_tie_ack0", ack0, 1);
        for (int k = 0; k < 5; k++) step();

        // Addresses other than 0.
        do_reset();
        set_txn(0, 1'b1, 2'd0, 32'h1234);
        for (int k = 0; k < 3; k++) step();
        set_txn(0, 1'b0, 2'd2, '0);
        step(); step();
        check("a2_ack0", ack0, 1);
        check("a2_rdata0", rdata0, 0);
        step();
        set_txn(1, 1'b1, 2'd3, 32'hDEAD);
        for (int k = 0; k < 3; k++) step();
        check("a3_pio", pio_out, 32'h1234);

        // Randomized traffic with occasional resets and stats clears.
        mode = 2;
        for (int k = 0; k < 2000; k++) begin
            reset_n = ($urandom_range(0, 199) != 0);
`ifdef PIO_ARB_WAIT_STATS_EN
            stats_clr = ($urandom_range(0, 15) == 0);
`endif
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
